dds_cfg_seq: RTL and testbench

//  Sequencer that owns the 16-bit spi_master instance driving an AD9833-style DDS chip.

---
 rtl/dds_cfg_seq_if.sv | 25 ++
 rtl/dds_cfg_seq.sv | 154 +++++++++++++++
 tb/tb_dds_cfg_seq.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_cfg_seq_if.sv
// Request and SPI-side signals of the DDS configuration sequencer.
// slave: the sequencer itself; master: tuning logic plus spi_master.
// Carries no clock; clk/rst stay plain ports on the modules.
interface dds_cfg_seq_if;
  logic        upd;
  logic [27:0] freq_word;
  logic [11:0] phase_word;
  logic [1:0]  wave_sel;
  logic        busy;
  logic        cfg_done;
  logic        err;
  logic        spi_start;
  logic [15:0] spi_data;
  logic        spi_done;

  modport slave (
    input  upd, freq_word, phase_word, wave_sel, spi_done,
    output busy, cfg_done, err, spi_start, spi_data
  );

  modport master (
    output upd, freq_word, phase_word, wave_sel, spi_done,
    input  busy, cfg_done, err, spi_start, spi_data
  );
endinterface

// File: rtl/dds_cfg_seq.sv
// Turns each update request into a 5-word SPI sequence for an AD9833-style DDS.
// Latency: upd in cycle 0 gives spi_start in cycle 1; words spaced GAP_CYCLES after spi_done.
// Backpressure: waits on spi_done per word (bounded by timeout); requests arriving while busy coalesce into one pending update.
module dds_cfg_seq #(
  parameter int          GAP_CYCLES     = 4,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter bit          AUTO_INIT      = 1'b1,
  parameter logic [27:0] INIT_FREQ      = 28'd0,
  parameter logic [11:0] INIT_PHASE     = 12'd0,
  parameter logic [1:0]  INIT_WAVE      = 2'd0
) (
  input  logic         clk,
  input  logic         rst,
  dds_cfg_seq_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef struct packed {
    logic [27:0] freq;
    logic [11:0] phase;
    logic [1:0]  wave;
  } cfg_t;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

  localparam cfg_t INIT_CFG = {INIT_FREQ, INIT_PHASE, INIT_WAVE};

  state_t          state;
  logic [2:0]      word_idx;
  logic            pending;
  logic            init_req;
  cfg_t            cur_cfg;
  cfg_t            pend_cfg;
  logic [TW-1:0]   tcnt;
  logic [GW-1:0]   gcnt;

  cfg_t            req_cfg;
  cfg_t            launch_cfg;
  cfg_t            resume_cfg;
  logic            gap_done;
  logic            wait_expired;

  // Control-register waveform bits: MODE for triangle, OPBITEN(+DIV2) for square outputs.
  function automatic logic [15:0] wave_bits(input logic [1:0] w);
    case (w)
      2'b00:   return 16'h0000;
      2'b01:   return 16'h0002;
      2'b10:   return 16'h0028;
      default: return 16'h0020;
    endcase
  endfunction

  // Word idx 0 holds the chip in reset while FREQ0/PHASE0 load; idx 4 releases it.
  function automatic logic [15:0] word_of(input cfg_t c, input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'h2100 | wave_bits(c.wave);
      3'd1:    return 16'h4000 | {2'b00, c.freq[13:0]};
      3'd2:    return 16'h4000 | {2'b00, c.freq[27:14]};
      3'd3:    return 16'hC000 | {4'h0, c.phase};
      default: return 16'h2000 | wave_bits(c.wave);
    endcase
  endfunction

  assign req_cfg      = {bus.freq_word, bus.phase_word, bus.wave_sel};
  assign launch_cfg   = init_req ? INIT_CFG : req_cfg;
  // A request landing on the final gap exit is newer than anything pending.
  assign resume_cfg   = bus.upd ? req_cfg : pend_cfg;
  assign gap_done     = (gcnt == GW'(GAP_CYCLES));
  assign wait_expired = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Sequencer FSM with registered outputs; later assignments in a branch override the pending capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      word_idx      <= 3'd0;
      pending       <= 1'b0;
      init_req      <= AUTO_INIT;
      cur_cfg       <= '0;
      pend_cfg      <= '0;
      tcnt          <= '0;
      gcnt          <= '0;
      bus.busy      <= 1'b0;
      bus.cfg_done  <= 1'b0;
      bus.err       <= 1'b0;
      bus.spi_start <= 1'b0;
      bus.spi_data  <= 16'h0000;
    end else begin
      bus.cfg_done  <= 1'b0;
      bus.err       <= 1'b0;
      bus.spi_start <= 1'b0;
      if (bus.upd && (state != IDLE || init_req)) begin
        pending  <= 1'b1;
        pend_cfg <= req_cfg;
      end
      case (state)
        IDLE: begin
          if (init_req || bus.upd) begin
            init_req      <= 1'b0;
            cur_cfg       <= launch_cfg;
            word_idx      <= 3'd0;
            bus.spi_start <= 1'b1;
            bus.spi_data  <= word_of(launch_cfg, 3'd0);
            bus.busy      <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          tcnt  <= TW'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (bus.spi_done) begin
            gcnt  <= GW'(1);
            state <= GAP;
          end else if (wait_expired) begin
            bus.err  <= 1'b1;
            pending  <= 1'b0;
            bus.busy <= 1'b0;
            word_idx <= 3'd0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          if (!gap_done) begin
            gcnt <= gcnt + GW'(1);
          end else if (word_idx != 3'd4) begin
            word_idx      <= word_idx + 3'd1;
            bus.spi_start <= 1'b1;
            bus.spi_data  <= word_of(cur_cfg, word_idx + 3'd1);
            state         <= LOAD;
          end else begin
            bus.cfg_done <= 1'b1;
            word_idx     <= 3'd0;
            if (pending || bus.upd) begin
              pending       <= 1'b0;
              cur_cfg       <= resume_cfg;
              bus.spi_start <= 1'b1;
              bus.spi_data  <= word_of(resume_cfg, 3'd0);
              state         <= LOAD;
            end else begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_cfg_seq.sv
// Bench for dds_cfg_seq: random update traffic against a timing/scoreboard model,
// plus literal checks of word encodings, coalescing, timeout and reset behaviour.
// u0 runs with AUTO_INIT=0 for the main traffic; u1 runs with AUTO_INIT=1 for init/reset.
module tb_dds_cfg_seq;
  localparam int G = 4;
  localparam int T = 40;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  dds_cfg_seq_if bus0();
  dds_cfg_seq_if bus1();

  dds_cfg_seq #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .AUTO_INIT(1'b0),
                .INIT_FREQ(28'h0), .INIT_PHASE(12'h0), .INIT_WAVE(2'd0))
    u0 (.clk(clk), .rst(rst0), .bus(bus0));

  dds_cfg_seq #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .AUTO_INIT(1'b1),
                .INIT_FREQ(28'hABCDEF1), .INIT_PHASE(12'h123), .INIT_WAVE(2'd1))
    u1 (.clk(clk), .rst(rst1), .bus(bus1));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Word table straight from the chip's register map, using division for the freq halves.
  function automatic logic [15:0] ref_word(input logic [27:0] f, input logic [11:0] p,
                                           input logic [1:0] w, input int i);
    int fi;
    logic [15:0] wb, r;
    fi = int'(f);
    case (w)
      2'd0: wb = 16'h0000;
      2'd1: wb = 16'h0002;
      2'd2: wb = 16'h0028;
      default: wb = 16'h0020;
    endcase
    case (i)
      0: r = 16'h2100 | wb;
      1: r = 16'h4000 + 16'(fi % 16384);
      2: r = 16'h4000 + 16'(fi / 16384);
      3: r = 16'hC000 + 16'(p);
      default: r = 16'h2000 | wb;
    endcase
    return r;
  endfunction

  // ---------------- model for u0 ----------------
  logic [15:0] exp_q[$];
  logic [15:0] log_q[$];
  bit m_busy = 1'b0, m_pend = 1'b0, in_wait = 1'b0, drop_mode = 1'b0;
  logic [27:0] pf;
  logic [11:0] pp;
  logic [1:0]  pw;
  logic [15:0] cur_word;
  int start_due = -1, done_due = -1, err_due = -1, seq_end = -1;
  int words_done = 0, resp_at = -1, spur_at = -1;
  int n_starts = 0, n_cfg_done = 0, n_err = 0;

  task automatic push_seq(input logic [27:0] f, input logic [11:0] p, input logic [1:0] w);
    for (int i = 0; i < 5; i++) exp_q.push_back(ref_word(f, p, w, i));
    words_done = 0;
  endtask

  // Per-cycle compare, spi_master responder and model update for u0.
  always @(negedge clk) begin
    if (rst0) begin
      bus0.spi_done = 1'b0;
      chk("rst_busy", 32'(bus0.busy), 32'd0);
      chk("rst_spi_start", 32'(bus0.spi_start), 32'd0);
      chk("rst_spi_data", 32'(bus0.spi_data), 32'd0);
      chk("rst_cfg_done", 32'(bus0.cfg_done), 32'd0);
      chk("rst_err", 32'(bus0.err), 32'd0);
    end else begin
      chk("spi_start", 32'(bus0.spi_start), 32'(start_due == cyc));
      if (bus0.spi_start) begin
        n_starts++;
        log_q.push_back(bus0.spi_data);
        chk("word_available", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("spi_data", 32'(bus0.spi_data), 32'(exp_q.pop_front()));
        cur_word = bus0.spi_data;
        in_wait = 1'b1;
        if (drop_mode) err_due = cyc + T;
        else resp_at = cyc + int'($urandom_range(1, 12));
      end else if (in_wait) begin
        chk("spi_data_hold", 32'(bus0.spi_data), 32'(cur_word));
      end
      chk("cfg_done", 32'(bus0.cfg_done), 32'(done_due == cyc));
      chk("err", 32'(bus0.err), 32'(err_due == cyc));
      chk("busy", 32'(bus0.busy), 32'(m_busy));
      if (bus0.cfg_done) n_cfg_done++;
      if (bus0.err) n_err++;
      bus0.spi_done = (cyc == resp_at) || (cyc == spur_at);
      if (bus0.upd) begin
        if (!m_busy) begin
          push_seq(bus0.freq_word, bus0.phase_word, bus0.wave_sel);
          m_busy = 1'b1;
          start_due = cyc + 1;
        end else begin
          m_pend = 1'b1;
          pf = bus0.freq_word; pp = bus0.phase_word; pw = bus0.wave_sel;
        end
      end
      if (cyc == resp_at) begin
        in_wait = 1'b0;
        words_done++;
        if (words_done < 5) start_due = cyc + G + 1;
        else seq_end = cyc + G;
        if ($urandom_range(0, 2) == 0) spur_at = cyc + 2;
      end
      if (cyc == seq_end) begin
        done_due = cyc + 1;
        if (m_pend) begin
          push_seq(pf, pp, pw);
          m_pend = 1'b0;
          start_due = cyc + 1;
        end else begin
          m_busy = 1'b0;
        end
      end
      if (cyc == err_due - 1) begin
        m_busy = 1'b0;
        m_pend = 1'b0;
        in_wait = 1'b0;
        exp_q.delete();
      end
    end
  end

  // ---------------- u1 observer/responder ----------------
  logic [15:0] log1[$];
  int n_start1 = 0, n_cd1 = 0, last_done1 = -1, resp1 = -1, first_start1 = -1;

  // Fixed-latency responder for u1; checks the done-to-start spacing within a sequence.
  always @(negedge clk) begin
    if (rst1) begin
      bus1.spi_done = 1'b0;
      resp1 = -1;
      last_done1 = -1;
    end else begin
      if (bus1.spi_start) begin
        if (log1.size() == 0) first_start1 = cyc;
        log1.push_back(bus1.spi_data);
        n_start1++;
        if (last_done1 >= 0) chk("gap1", 32'(cyc - last_done1), 32'(G + 1));
        resp1 = cyc + 3;
      end
      if (bus1.cfg_done) n_cd1++;
      bus1.spi_done = (cyc == resp1);
      if (cyc == resp1) last_done1 = cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_now(input logic [27:0] f, input logic [11:0] p, input logic [1:0] w);
    bus0.freq_word = f; bus0.phase_word = p; bus0.wave_sel = w; bus0.upd = 1'b1;
    @(posedge clk); #1;
    bus0.upd = 1'b0;
    bus0.freq_word = 28'($urandom); bus0.phase_word = 12'($urandom); bus0.wave_sel = 2'($urandom);
  endtask

  task automatic send(input logic [27:0] f, input logic [11:0] p, input logic [1:0] w);
    @(posedge clk); #1;
    send_now(f, p, w);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((m_busy || bus0.busy) && k < 3000) begin @(posedge clk); #1; k++; end
    chk("idle_reached", 32'(k < 3000), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_cd(input int target, output bit dropped);
    int k = 0;
    dropped = 1'b0;
    while (n_cfg_done < target && k < 3000) begin
      @(negedge clk); #1;
      if (n_cfg_done < target && !bus0.busy) dropped = 1'b1;
      k++;
    end
    chk("cfg_done_count", 32'(n_cfg_done), 32'(target));
  endtask

  logic [15:0] t2_exp [5] = '{16'h2100, 16'h4567, 16'h448D, 16'hC0AB, 16'h2000};
  logic [15:0] t4_exp [5] = '{16'h2128, 16'h5555, 16'h4155, 16'hC321, 16'h2028};
  logic [15:0] i1_exp [5] = '{16'h2102, 16'h5EF1, 16'h6AF3, 16'hC123, 16'h2002};
  logic [15:0] t3_first [3] = '{16'h2102, 16'h2128, 16'h2120};
  logic [15:0] t3_last  [3] = '{16'h2002, 16'h2028, 16'h2020};

  initial begin
    int base, cd, e0, k, hold;
    bit dropped;
    bus0.upd = 1'b0; bus0.freq_word = '0; bus0.phase_word = '0; bus0.wave_sel = '0;
    bus1.upd = 1'b0; bus1.freq_word = '0; bus1.phase_word = '0; bus1.wave_sel = '0;

    // Model pinned against hand-computed encodings.
    chk("model_freq_lsb", 32'(ref_word(28'h1234567, 12'h0AB, 2'd0, 1)), 32'h4567);
    chk("model_freq_msb", 32'(ref_word(28'h1234567, 12'h0AB, 2'd0, 2)), 32'h448D);
    chk("model_phase", 32'(ref_word(28'h1234567, 12'h0AB, 2'd0, 3)), 32'hC0AB);

    // Reset held: outputs zero (u0 checked every cycle by the monitor).
    repeat (5) @(posedge clk);
    #1;
    chk("u1_rst_busy", 32'(bus1.busy), 32'd0);
    chk("u1_rst_spi_data", 32'(bus1.spi_data), 32'd0);
    chk("u1_rst_spi_start", 32'(bus1.spi_start), 32'd0);
    rst0 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("no_start_after_release", 32'(n_starts), 32'd0);

    // Basic sequence with literal words.
    base = log_q.size(); cd = n_cfg_done;
    send(28'h1234567, 12'h0AB, 2'd0);
    wait_idle();
    for (int i = 0; i < 5; i++) chk("seq_word", 32'(log_q[base + i]), 32'(t2_exp[i]));
    chk("single_cfg_done", 32'(n_cfg_done - cd), 32'd1);
    chk("busy_low_after", 32'(bus0.busy), 32'd0);

    // Waveform control bits in first and last words.
    for (int w = 1; w < 4; w++) begin
      base = log_q.size();
      send(28'($urandom), 12'($urandom), 2'(w));
      wait_idle();
      chk("wave_first", 32'(log_q[base]), 32'(t3_first[w - 1]));
      chk("wave_last", 32'(log_q[base + 4]), 32'(t3_last[w - 1]));
    end

    // Two requests during word 1 coalesce into one extra sequence with the later values.
    base = log_q.size(); cd = n_cfg_done;
    send(28'h0123456, 12'h456, 2'd0);
    k = 0;
    while (n_starts < base + 2 && k < 500) begin @(posedge clk); #1; k++; end
    send(28'h0AAAAAA, 12'h111, 2'd1);
    send(28'h0555555, 12'h321, 2'd2);
    wait_cd(cd + 2, dropped);
    chk("busy_held_coalesce", 32'(dropped), 32'd0);
    wait_idle();
    chk("coalesce_starts", 32'(log_q.size() - base), 32'd10);
    for (int i = 0; i < 5; i++) chk("coalesce_word", 32'(log_q[base + 5 + i]), 32'(t4_exp[i]));

    // Request on the exact final gap-exit cycle is serviced right away.
    cd = n_cfg_done; base = log_q.size();
    send(28'($urandom), 12'($urandom), 2'($urandom));
    k = 0;
    while (seq_end < cyc && k < 500) begin @(posedge clk); #1; k++; end
    while (cyc < seq_end && k < 1000) begin @(posedge clk); #1; k++; end
    send_now(28'h0555555, 12'h321, 2'd2);
    wait_cd(cd + 2, dropped);
    chk("busy_held_exit", 32'(dropped), 32'd0);
    wait_idle();
    chk("exit_req_word", 32'(log_q[base + 6]), 32'h5555);

    // Timeout: no spi_done, err pulse, then normal operation resumes.
    drop_mode = 1'b1; e0 = n_err;
    send(28'($urandom), 12'($urandom), 2'($urandom));
    k = 0;
    while (n_err == e0 && k < 500) begin @(posedge clk); #1; k++; end
    chk("err_pulses", 32'(n_err - e0), 32'd1);
    drop_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_err", 32'(bus0.busy), 32'd0);
    cd = n_cfg_done;
    send(28'h1234567, 12'h0AB, 2'd0);
    wait_idle();
    chk("recover_cfg_done", 32'(n_cfg_done - cd), 32'd1);

    // Random traffic with random spacing.
    for (int n = 0; n < 40; n++) begin
      hold = int'($urandom_range(0, 50));
      repeat (hold) @(posedge clk);
      send(28'($urandom), 12'($urandom), 2'($urandom));
    end
    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("no_pending_left", 32'(m_pend), 32'd0);

    // Auto-init after reset release, reset mid-word-2, restart from word 0.
    @(posedge clk); #1;
    rst1 = 1'b0;
    base = cyc;
    k = 0;
    while (log1.size() < 3 && k < 500) begin @(negedge clk); #1; k++; end
    chk("init_first_start", 32'(first_start1), 32'(base + 1));
    chk("init_busy_before_rst", 32'(bus1.busy), 32'd1);
    #1; rst1 = 1'b1; #1;
    chk("async_rst_busy", 32'(bus1.busy), 32'd0);
    chk("async_rst_spi_data", 32'(bus1.spi_data), 32'd0);
    chk("async_rst_spi_start", 32'(bus1.spi_start), 32'd0);
    chk("async_rst_err", 32'(bus1.err), 32'd0);
    hold = n_start1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_start_in_rst", 32'(n_start1 - hold), 32'd0);
    log1.delete();
    cd = n_cd1;
    rst1 = 1'b0;
    base = cyc;
    k = 0;
    while (n_cd1 == cd && k < 500) begin @(posedge clk); #1; k++; end
    repeat (20) @(posedge clk);
    #1;
    chk("init_restart_start", 32'(first_start1), 32'(base + 1));
    chk("init_words_count", 32'(log1.size()), 32'd5);
    for (int i = 0; i < 5 && i < log1.size(); i++) chk("init_word", 32'(log1[i]), 32'(i1_exp[i]));
    chk("init_cfg_done", 32'(n_cd1 - cd), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
